// File: rtl/md_unit.sv
// md_unit: multiply/divide unit of the execute stage.
// Holds architectural HI/LO and models multi-cycle latency with a busy flag.
// The result is computed at the accept edge and then held in a pending register.
// It is committed to HI/LO when the latency counter expires.
// Optional feature macro: MD_MADD_EN enables the madd/maddu/msub/msubu accumulate ops (codes 7-10).
//
// Handshake: an op is accepted at a rising edge when start=1, flush=0, busy=0 and md_op is a
// supported code. Long ops raise busy for exactly N cycles after that edge. The result is committed
// at the last edge of the window. There is no back-pressure beyond busy; start while busy is ignored.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  md_op,
    input  logic        start,
    input  logic        flush,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    // md_op encodings
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MD_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

    logic [31:0]   r_hi;
    logic [31:0]   r_lo;
    logic [31:0]   r_phi;
    logic [31:0]   r_plo;
    logic          r_busy;
    logic          r_wr;
    logic [CW-1:0] r_cnt;

    logic [63:0]   w_smul;
    logic [63:0]   w_umul;
    logic [31:0]   w_div_b;
    logic [31:0]   w_abs_a;
    logic [31:0]   w_abs_b;
    logic [31:0]   w_mag_q;
    logic [31:0]   w_mag_r;
    logic [31:0]   w_squo;
    logic [31:0]   w_srem;
    logic [31:0]   w_uquo;
    logic [31:0]   w_urem;

    logic          w_op_valid;
    logic          w_is_long;
    logic          w_is_mthi;
    logic          w_is_mtlo;
    logic          w_wr;
    logic [CW-1:0] w_cnt_init;
    logic [63:0]   w_res;
    logic          w_accept;

    // Arithmetic datapath: sign-extended operands give the signed product mod 2^64; the signed
    // divide works on magnitudes so 0x80000000 / -1 wraps to 0x80000000 without overflow.
    always_comb begin
        w_smul  = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        w_umul  = {32'd0, a} * {32'd0, b};
        w_div_b = (b == 32'd0) ? 32'd1 : b;
        w_abs_a = a[31] ? (32'd0 - a) : a;
        w_abs_b = w_div_b[31] ? (32'd0 - w_div_b) : w_div_b;
        w_mag_q = w_abs_a / w_abs_b;
        w_mag_r = w_abs_a % w_abs_b;
        w_squo  = (a[31] ^ w_div_b[31]) ? (32'd0 - w_mag_q) : w_mag_q;
        w_srem  = a[31] ? (32'd0 - w_mag_r) : w_mag_r;
        w_uquo  = a / w_div_b;
        w_urem  = a % w_div_b;
    end

    // Op decode: selects the pending result, latency and whether the result is committed
    always_comb begin
        w_op_valid = 1'b0;
        w_is_long  = 1'b0;
        w_is_mthi  = 1'b0;
        w_is_mtlo  = 1'b0;
        w_wr       = 1'b1;
        w_cnt_init = '0;
        w_res      = 64'd0;
        case (md_op)
            OP_MULT: begin
                w_op_valid = 1'b1;
                w_is_long  = 1'b1;
                w_cnt_init = CW'(MULT_CYCLES);
                w_res      = w_smul;
            end
            OP_MULTU: begin
                w_op_valid = 1'b1;
                w_is_long  = 1'b1;
                w_cnt_init = CW'(MULT_CYCLES);
                w_res      = w_umul;
            end
            OP_DIV: begin
                w_op_valid = 1'b1;
                w_is_long  = 1'b1;
                w_cnt_init = CW'(DIV_CYCLES);
                w_res      = {w_srem, w_squo};
                w_wr       = (b != 32'd0);
            end
            OP_DIVU: begin
                w_op_valid = 1'b1;
                w_is_long  = 1'b1;
                w_cnt_init = CW'(DIV_CYCLES);
                w_res      = {w_urem, w_uquo};
                w_wr       = (b != 32'd0);
            end
            OP_MTHI: begin
                w_op_valid = 1'b1;
                w_is_mthi  = 1'b1;
            end
            OP_MTLO: begin
                w_op_valid = 1'b1;
                w_is_mtlo  = 1'b1;
            end
`ifdef MD_MADD_EN
            OP_MADD: begin
                w_op_valid = 1'b1;
                w_is_long  = 1'b1;
                w_cnt_init = CW'(MULT_CYCLES);
                w_res      = {r_hi, r_lo} + w_smul;
            end
            OP_MADDU: begin
                w_op_valid = 1'b1;
                w_is_long  = 1'b1;
                w_cnt_init = CW'(MULT_CYCLES);
                w_res      = {r_hi, r_lo} + w_umul;
            end
            OP_MSUB: begin
                w_op_valid = 1'b1;
                w_is_long  = 1'b1;
                w_cnt_init = CW'(MULT_CYCLES);
                w_res      = {r_hi, r_lo} - w_smul;
            end
            OP_MSUBU: begin
                w_op_valid = 1'b1;
                w_is_long  = 1'b1;
                w_cnt_init = CW'(MULT_CYCLES);
                w_res      = {r_hi, r_lo} - w_umul;
            end
`endif
            default: begin
                w_op_valid = 1'b0;
            end
        endcase
        w_accept = start & ~flush & ~r_busy & w_op_valid;
    end

    // HI/LO, pending result and latency counter; a long op in flight always runs to commit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hi   <= 32'd0;
            r_lo   <= 32'd0;
            r_phi  <= 32'd0;
            r_plo  <= 32'd0;
            r_busy <= 1'b0;
            r_wr   <= 1'b0;
            r_cnt  <= '0;
        end else if (r_busy) begin
            if (r_cnt == CW'(1)) begin
                r_busy <= 1'b0;
                r_cnt  <= '0;
                if (r_wr) begin
                    r_hi <= r_phi;
                    r_lo <= r_plo;
                end
            end else begin
                r_cnt <= r_cnt - CW'(1);
            end
        end else if (w_accept) begin
            if (w_is_mthi) begin
                r_hi <= a;
            end
            if (w_is_mtlo) begin
                r_lo <= a;
            end
            if (w_is_long) begin
                r_phi  <= w_res[63:32];
                r_plo  <= w_res[31:0];
                r_wr   <= w_wr;
                r_cnt  <= w_cnt_init;
                r_busy <= 1'b1;
            end
        end
    end

    assign busy = r_busy;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed and random checks of md_unit with a HI/LO scoreboard.
module tb_md_unit;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  md_op;
    logic        start;
    logic        flush;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    logic [63:0] exp_q[$];
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    int          n_tests;
    int          n_fail;

    md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .rst   (rst),
        .a     (a),
        .b     (b),
        .md_op (md_op),
        .start (start),
        .flush (flush),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // reference model of one op on the bench's own HI/LO copy
    function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] x,
                                          input logic [31:0] y, input logic [63:0] acc);
        longint sx;
        longint sy;
        longint q;
        longint r;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        model = acc;
        case (op)
            4'd1: begin p = sx * sy; model = p; end
            4'd2: model = {32'd0, x} * {32'd0, y};
            4'd3: if (y != 32'd0) begin
                q = sx / sy;
                r = sx % sy;
                model = {r[31:0], q[31:0]};
            end
            4'd4: if (y != 32'd0) model = {x % y, x / y};
            4'd7: begin p = sx * sy; model = acc + p; end
            4'd8: model = acc + ({32'd0, x} * {32'd0, y});
            4'd9: begin p = sx * sy; model = acc - p; end
            4'd10: model = acc - ({32'd0, x} * {32'd0, y});
            default: model = acc;
        endcase
    endfunction

    // driver: presents an op for one cycle starting at the current negedge
    task automatic issue(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                         input logic fl);
        md_op = op;
        a     = x;
        b     = y;
        start = 1'b1;
        flush = fl;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        md_op = 4'd0;
    endtask

    // long op: push expectation, check the busy window while scrambling operands, then compare
    task automatic run_long(input string tag, input logic [3:0] op, input logic [31:0] x,
                            input logic [31:0] y, input int n);
        logic [63:0] e;
        e = model(op, x, y, {m_hi, m_lo});
        exp_q.push_back(e);
        issue(op, x, y, 1'b0);
        for (int i = 0; i < n; i++) begin
            check({tag, "_busy"}, {31'd0, busy}, 32'd1);
            a = $urandom;
            b = $urandom;
            @(negedge clk);
        end
        check({tag, "_done"}, {31'd0, busy}, 32'd0);
        if (exp_q.size() == 0) begin
            check({tag, "_queue"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_hi"}, hi, e[63:32]);
            check({tag, "_lo"}, lo, e[31:0]);
            m_hi = e[63:32];
            m_lo = e[31:0];
        end
    endtask

    task automatic mt(input logic [3:0] op, input logic [31:0] x);
        issue(op, x, 32'd0, 1'b0);
        if (op == 4'd5) m_hi = x; else m_lo = x;
        check("mt_busy", {31'd0, busy}, 32'd0);
        check(op == 4'd5 ? "mthi" : "mtlo", op == 4'd5 ? hi : lo, x);
    endtask

    // no-op style op: busy never rises and HI/LO keep the model values
    task automatic run_nop(input string tag, input logic [3:0] op, input logic fl);
        issue(op, 32'd5, 32'd5, fl);
        for (int i = 0; i < 3; i++) begin
            check({tag, "_busy"}, {31'd0, busy}, 32'd0);
            @(negedge clk);
        end
        check({tag, "_hi"}, hi, m_hi);
        check({tag, "_lo"}, lo, m_lo);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        m_hi    = 32'd0;
        m_lo    = 32'd0;
        rst     = 1'b0;
        a       = 32'd0;
        b       = 32'd0;
        md_op   = 4'd0;
        start   = 1'b0;
        flush   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        run_long("mult_neg", 4'd1, 32'hFFFFFFFE, 32'd3, MC);
        check("mult_neg_hi_const", hi, 32'hFFFFFFFF);
        check("mult_neg_lo_const", lo, 32'hFFFFFFFA);
        // back-to-back: accepted in the first cycle after busy falls
        run_long("div_neg", 4'd3, 32'hFFFFFFF9, 32'd2, DC);
        check("div_neg_lo_const", lo, 32'hFFFFFFFD);
        check("div_neg_hi_const", hi, 32'hFFFFFFFF);
        run_long("divu", 4'd4, 32'hFFFFFFF9, 32'd2, DC);
        check("divu_lo_const", lo, 32'h7FFFFFFC);
        check("divu_hi_const", hi, 32'h00000001);
        run_long("div_ovf", 4'd3, 32'h80000000, 32'hFFFFFFFF, DC);
        check("div_ovf_lo_const", lo, 32'h80000000);
        run_long("multu_max", 4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, MC);
        check("multu_max_hi_const", hi, 32'hFFFFFFFE);

        mt(4'd5, 32'h12345678);
        mt(4'd6, 32'h9ABCDEF0);
        check("mt_hi_kept", hi, 32'h12345678);

        mt(4'd5, 32'd1);
        mt(4'd6, 32'd2);
        run_long("div_zero", 4'd3, 32'd77, 32'd0, DC);
        check("div_zero_hi_const", hi, 32'd1);
        check("div_zero_lo_const", lo, 32'd2);
        run_long("divu_zero", 4'd4, 32'd77, 32'd0, DC);

        run_nop("flush_mult", 4'd1, 1'b1);
        run_nop("op0", 4'd0, 1'b0);
        run_nop("op11", 4'd11, 1'b0);
        run_nop("op15", 4'd15, 1'b0);

`ifdef MD_MADD_EN
        mt(4'd5, 32'd0);
        mt(4'd6, 32'hFFFFFFFF);
        run_long("maddu", 4'd8, 32'd1, 32'd1, MC);
        check("maddu_hi_const", hi, 32'd1);
        check("maddu_lo_const", lo, 32'd0);
        run_long("madd", 4'd7, 32'hFFFFFFFF, 32'd3, MC);
        run_long("msub", 4'd9, 32'hFFFFFFFE, 32'd7, MC);
        run_long("msubu", 4'd10, 32'hFFFFFFFE, 32'd7, MC);
`else
        run_nop("madd_off", 4'd7, 1'b0);
        run_nop("msubu_off", 4'd10, 1'b0);
`endif

        for (int i = 0; i < 8; i++) begin
            logic [3:0]  op;
            logic [31:0] x;
            logic [31:0] y;
            op = 4'($urandom_range(1, 4));
            x  = $urandom;
            y  = $urandom;
            if (i == 3) y = y >> $urandom_range(8, 28);
            run_long("rand", op, x, y, (op <= 4'd2) ? MC : DC);
        end

        // reset during a divide: immediate clear and no late commit
        mt(4'd5, 32'hDEAD0001);
        mt(4'd6, 32'hBEEF0002);
        issue(4'd3, 32'd100, 32'd7, 1'b0);
        repeat (3) @(negedge clk);
        check("mid_busy", {31'd0, busy}, 32'd1);
        rst = 1'b0;
        #1;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_hi", hi, 32'd0);
        check("mid_rst_lo", lo, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < DC + 2; i++) begin
            @(negedge clk);
            check("post_rst_busy", {31'd0, busy}, 32'd0);
        end
        check("post_rst_hi", hi, 32'd0);
        check("post_rst_lo", lo, 32'd0);
        m_hi = 32'd0;
        m_lo = 32'd0;
        run_long("after_rst", 4'd1, 32'd6, 32'd7, MC);

        if (exp_q.size() != 0) check("queue_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
